prod_bcd_conv: RTL and testbench

- Downstream stage of the sequential 4x4 multiplier.
- Watches the multiplier's `res`/`finish` pair and captures each new product.
- Converts the product to packed BCD with a sequential shift-add-3 (double-dabble) engine, one shift per clock.
- Presents the digits, with a one-cycle valid strobe, to the display/reporting logic.

---
 rtl/prod_bcd_conv.sv | 146 ++++++++++++++
 tb/tb_prod_bcd_conv.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prod_bcd_conv.sv
// Binary-to-BCD stage behind the sequential multiplier: captures each new
// product on a finish rising edge and converts it by shift-add-3, one bit/clock.
//
// Ports:
//   clk, rst      rising-edge clock, async active-high reset
//   res, finish   product and done level from the multiplier
//   bcd           packed BCD, ones digit in [3:0]
//   valid         one-cycle strobe when bcd has just been updated
//   busy          conversion in progress
//   overrun       sticky, a start edge was dropped while busy
module prod_bcd_conv #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter int CW     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      res,
  input  logic                  finish,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int BW = 4 * DIGITS;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] MAXV = (64'd1 << WIDTH) - 64'd1;

  if (pow10(DIGITS) <= MAXV) begin : g_digits_chk
    $error("prod_bcd_conv: DIGITS too small for WIDTH");
  end

  if ((64'd1 << CW) <= 64'(WIDTH)) begin : g_cw_chk
    $error("prod_bcd_conv: CW too small for WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             finish_q, finish_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]    work_q, work_d;
  logic [BW-1:0]    adj;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             ovr_q, ovr_d;
  logic             start;

  assign finish_d = finish;
  assign start    = finish & ~finish_q;

  // Digits are corrected independently; a digit >= 5 would reach >= 10
  // after the shift, so the +3 pushes its overflow into the next digit.
  always_comb begin
    adj = work_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (work_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          bin_d   = res;
          work_d  = '0;
          cnt_d   = '0;
          ovr_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (start) ovr_d = 1'b1;
        {work_d, bin_d} = {adj, bin_q} << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = S_DONE;
      end
      S_DONE: begin
        if (start) ovr_d = 1'b1;
        bcd_d   = work_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      finish_q <= 1'b0;
      bin_q    <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      bcd_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      finish_q <= finish_d;
      bin_q    <= bin_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      bcd_q    <= bcd_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      ovr_q    <= ovr_d;
    end
  end

  assign bcd     = bcd_q;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_prod_bcd_conv.sv
// Directed bench for prod_bcd_conv: latency, results, overrun, reset, sweep.
module tb_prod_bcd_conv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  res = 8'd0;
  logic        finish = 1'b0;
  logic [11:0] bcd;
  logic        valid;
  logic        busy;
  logic        overrun;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  prod_bcd_conv dut (
    .clk(clk), .rst(rst), .res(res), .finish(finish),
    .bcd(bcd), .valid(valid), .busy(busy), .overrun(overrun)
  );

  // Raise finish with operand v, wait (bounded) for valid, then drop finish.
  task automatic conv(input logic [7:0] v, output logic [11:0] b,
                      output int lat, output int bc, output logic v2);
    @(negedge clk);
    res = v;
    finish = 1'b1;
    lat = 0;
    bc = 0;
    b = 'x;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (busy) bc++;
      if (valid) begin
        b = bcd;
        break;
      end
    end
    @(negedge clk);
    v2 = valid;
    finish = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({bcd, valid, busy, overrun} !== 15'd0) begin
      bad++;
      $display("FAIL reset_state got=%h/%b%b%b want=000/000",
               bcd, valid, busy, overrun);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset busy=%b want=0", busy);
    end
  endtask

  task automatic test_42();
    logic [11:0] b; int lat; int bc; logic v2;
    conv(8'd42, b, lat, bc, v2);
    total++;
    if (b !== 12'h042) begin
      bad++; $display("FAIL r42_bcd got=%h want=042", b);
    end
    total++;
    if (lat !== 10) begin
      bad++; $display("FAIL r42_latency got=%0d want=10", lat);
    end
    total++;
    if (bc !== 9) begin
      bad++; $display("FAIL r42_busy_cycles got=%0d want=9", bc);
    end
    total++;
    if (v2 !== 1'b0) begin
      bad++; $display("FAIL r42_valid_width got=%b want=0", v2);
    end
    total++;
    if (overrun !== 1'b0) begin
      bad++; $display("FAIL r42_overrun got=%b want=0", overrun);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] b; int lat; int bc; logic v2;
    conv(8'd255, b, lat, bc, v2);
    total++;
    if (b !== 12'h255) begin
      bad++; $display("FAIL b2b_255 got=%h want=255", b);
    end
    conv(8'd0, b, lat, bc, v2);
    total++;
    if (b !== 12'h000) begin
      bad++; $display("FAIL b2b_0 got=%h want=000", b);
    end
    total++;
    if (lat !== 10) begin
      bad++; $display("FAIL b2b_0_valid got=%0d want=10", lat);
    end
  endtask

  task automatic test_hold();
    logic [11:0] b; int lat; int bc; logic v2;
    int drift;
    conv(8'd9, b, lat, bc, v2);
    total++;
    if (b !== 12'h009) begin
      bad++; $display("FAIL hold_9 got=%h want=009", b);
    end
    drift = 0;
    res = 8'd40;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bcd !== 12'h009 || valid !== 1'b0) drift++;
    end
    total++;
    if (drift !== 0) begin
      bad++; $display("FAIL hold_between got=%0d changes want=0", drift);
    end
    conv(8'd40, b, lat, bc, v2);
    total++;
    if (b !== 12'h040) begin
      bad++; $display("FAIL hold_40 got=%h want=040", b);
    end
  endtask

  task automatic test_overrun();
    logic [11:0] b; int lat; int bc; logic v2;
    int nval;
    logic [11:0] first;
    @(negedge clk);
    res = 8'd42;
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    res = 8'd99;
    @(negedge clk);
    finish = 1'b1;
    nval = 0;
    first = 'x;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (valid) begin
        nval++;
        if (nval == 1) first = bcd;
      end
    end
    total++;
    if (nval !== 1) begin
      bad++; $display("FAIL ovr_valid_count got=%0d want=1", nval);
    end
    total++;
    if (first !== 12'h042) begin
      bad++; $display("FAIL ovr_first_result got=%h want=042", first);
    end
    total++;
    if (overrun !== 1'b1) begin
      bad++; $display("FAIL ovr_flag got=%b want=1", overrun);
    end
    finish = 1'b0;
    @(negedge clk);
    total++;
    if (overrun !== 1'b1) begin
      bad++; $display("FAIL ovr_sticky got=%b want=1", overrun);
    end
    conv(8'd7, b, lat, bc, v2);
    total++;
    if (overrun !== 1'b0 || b !== 12'h007) begin
      bad++;
      $display("FAIL ovr_clear got=%b/%h want=0/007", overrun, b);
    end
  endtask

  task automatic test_reset_mid();
    int nval;
    int lat;
    logic [11:0] b;
    @(negedge clk);
    res = 8'd42;
    finish = 1'b1;
    nval = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (valid) nval++;
    end
    rst = 1'b1;
    #1;
    total++;
    if ({bcd, valid, busy, overrun} !== 15'd0) begin
      bad++;
      $display("FAIL rstmid_outputs got=%h/%b%b%b want=000/000",
               bcd, valid, busy, overrun);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (valid) nval++;
    end
    total++;
    if (nval !== 0) begin
      bad++; $display("FAIL rstmid_no_valid got=%0d want=0", nval);
    end
    rst = 1'b0;
    lat = 0;
    b = 'x;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (valid) begin
        b = bcd;
        break;
      end
    end
    total++;
    if (b !== 12'h042) begin
      bad++; $display("FAIL rstmid_rerun got=%h want=042", b);
    end
    total++;
    if (lat !== 10) begin
      bad++; $display("FAIL rstmid_latency got=%0d want=10", lat);
    end
    finish = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sweep();
    logic [11:0] b; int lat; int bc; logic v2;
    logic [11:0] exp;
    int nib_bad;
    for (int v = 0; v < 256; v++) begin
      conv(8'(v), b, lat, bc, v2);
      exp = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      nib_bad = 0;
      for (int d = 0; d < 3; d++)
        if (b[4*d +: 4] > 4'd9) nib_bad++;
      total++;
      if (b !== exp || lat !== 10 || nib_bad !== 0) begin
        bad++;
        $display("FAIL sweep_%0d got=%h lat=%0d want=%h lat=10",
                 v, b, lat, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_42();
    test_back_to_back();
    test_hold();
    test_overrun();
    test_reset_mid();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
